// File: rtl/led_rng_pkg.sv
// Shared definitions for the RNG-driven LED display: mode encoding,
// prescaler width helper and an elaboration-time parameter check.
// Latency / backpressure: n/a (package only).

// Expands to a named generate block that aborts elaboration when cond is false.
`define LED_RNG_PARAM_CHECK(label, cond, msg) \
    if (!(cond)) begin : label \
        $error(msg); \
    end

package led_rng_pkg;

    typedef enum logic [1:0] {
        MODE_SNAPSHOT = 2'd0,
        MODE_SCROLL   = 2'd1,
        MODE_PWM      = 2'd2,
        MODE_RSVD     = 2'd3
    } mode_e;

    // Prescaler counter width; never narrower than one bit.
    function automatic int prescaler_width(input int period);
        int w;
        w = $clog2(period);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One PWM LED channel: holds a duty value and compares it with the shared frame counter.
// Latency: duty loads on the edge after load=1; led is combinational from duty and pwm_cnt.
// Backpressure: none; load is accepted whenever enable=1.
//
// Ports:
//   clock, reset_n   clock and async active-low reset (clears duty)
//   enable           0 = hold duty
//   load             capture duty_in into duty
//   duty_in          new duty value
//   pwm_cnt          shared frame counter from the top level
//   led              1 while pwm_cnt < duty
module led_pwm_channel
    import led_rng_pkg::*;
#(
    parameter int PWM_BITS = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                load,
    input  logic [PWM_BITS-1:0] duty_in,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led
);

    logic [PWM_BITS-1:0] duty;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            duty <= '0;
        end else if (enable && load) begin
            duty <= duty_in;
        end
    end

    // Strict compare: duty 0 never lights, max duty is dark for one slot per frame.
    assign led = (pwm_cnt < duty);

endmodule

// File: rtl/led_rng_display.sv
// LED driver consuming one RNG word per prescaler period in snapshot, scroll or PWM mode.
// Latency: leds update on the edge after the consuming cycle (rng_take=1); PWM leds refresh every cycle.
// Backpressure: a tick without rng_valid is remembered as pending; the prescaler never stalls.
//
// Ports:
//   clock, reset_n   clock and async active-low reset
//   enable           1 = run, 0 = freeze all state
//   mode             0 snapshot, 1 scroll, 2 PWM, 3 behaves as snapshot
//   rng_word         random data; rng_valid marks it usable
//   rng_take         combinational pulse on the cycle rng_word is consumed
//   leds             registered LED drive
module led_rng_display
    import led_rng_pkg::*;
#(
    parameter int NUM_LEDS      = 4,
    parameter int PERIOD_CYCLES = 200000000,
    parameter int PWM_BITS      = 4,
    parameter int RNG_WIDTH     = 512
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [RNG_WIDTH-1:0] rng_word,
    input  logic                 rng_valid,
    output logic                 rng_take,
    output logic [NUM_LEDS-1:0]  leds
);

    `LED_RNG_PARAM_CHECK(g_err_num_leds, (NUM_LEDS >= 1) && (NUM_LEDS <= 32), "NUM_LEDS must be 1..32")
    `LED_RNG_PARAM_CHECK(g_err_pwm_bits, (PWM_BITS >= 1) && (PWM_BITS <= 8), "PWM_BITS must be 1..8")
    `LED_RNG_PARAM_CHECK(g_err_period, PERIOD_CYCLES >= 2, "PERIOD_CYCLES must be at least 2")
    `LED_RNG_PARAM_CHECK(g_err_width, RNG_WIDTH >= NUM_LEDS * PWM_BITS, "RNG_WIDTH too small for NUM_LEDS*PWM_BITS")

    localparam int PCW = prescaler_width(PERIOD_CYCLES);
    localparam logic [PCW-1:0] CNT_LAST = PCW'(PERIOD_CYCLES - 1);

    mode_e                mode_q;
    logic [PCW-1:0]       cnt;
    logic                 pending;
    logic [PWM_BITS-1:0]  pwm_cnt;
    logic [NUM_LEDS-1:0]  leds_nxt;
    logic [NUM_LEDS-1:0]  pwm_leds;
    logic [NUM_LEDS-1:0]  scroll_val;
    logic                 mode_chg;
    logic                 tick;
    logic                 update;
    logic                 unused_rng_bits;

    assign unused_rng_bits = ^rng_word;

    // A mode change pre-empts everything else in that cycle, including a tick.
    assign mode_chg = enable && (mode != mode_q);
    assign tick     = enable && (cnt == CNT_LAST);
    assign update   = enable && !mode_chg && (tick || pending) && rng_valid;
    assign rng_take = update;

    generate
        if (NUM_LEDS == 1) begin : g_scroll_one
            assign scroll_val = rng_word[0];
        end else begin : g_scroll_many
            assign scroll_val = {leds[NUM_LEDS-2:0], rng_word[0]};
        end
    endgenerate

    generate
        for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
            led_pwm_channel #(
                .PWM_BITS (PWM_BITS)
            ) u_chan (
                .clock   (clock),
                .reset_n (reset_n),
                .enable  (enable),
                .load    (update && (mode_q == MODE_PWM)),
                .duty_in (rng_word[i*PWM_BITS +: PWM_BITS]),
                .pwm_cnt (pwm_cnt),
                .led     (pwm_leds[i])
            );
        end
    endgenerate

    // leds keep their value through a mode change; PWM refreshes every cycle,
    // the other modes only on an update.
    always_comb begin
        leds_nxt = leds;
        if (!mode_chg) begin
            case (mode_q)
                MODE_PWM:    leds_nxt = pwm_leds;
                MODE_SCROLL: if (update) leds_nxt = scroll_val;
                default:     if (update) leds_nxt = rng_word[NUM_LEDS-1:0];
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_q  <= MODE_SNAPSHOT;
            cnt     <= '0;
            pending <= 1'b0;
            pwm_cnt <= '0;
            leds    <= '0;
        end else if (enable) begin
            mode_q <= mode_e'(mode);
            leds   <= leds_nxt;
            if (mode_chg) begin
                cnt     <= '0;
                pwm_cnt <= '0;
                pending <= 1'b0;
            end else begin
                cnt     <= tick ? '0 : cnt + PCW'(1);
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
                if (update) begin
                    pending <= 1'b0;
                end else if (tick) begin
                    pending <= 1'b1;
                end
            end
        end
    end

endmodule
